// File: rtl/glitch_seq_wb_if.sv
// glitch_seq_wb_if: Wishbone register bus between the host bridge and the glitch sequencer
interface glitch_seq_wb_if;
  logic       stb_i;
  logic       we_i;
  logic [3:0] adr_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;
  modport master (output stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
  modport slave (input stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/glitch_seq_wb.sv
// glitch_seq_wb: Wishbone-mapped glitch sequencer emitting trains of clock glitches after a delay
module glitch_seq_wb #(
  parameter int DELAY_W = 24,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  glitch_seq_wb_if.slave  bus,
  input  logic            clk_in,
  input  logic            trig_in,
  output logic            clk_out,
  output logic            irq_o,
  output logic [5:0]      ch_out
);
  localparam int NB = DELAY_W / 8;
  typedef enum logic [2:0] {IDLE, WAIT_TRIG, DELAY, PULSE, GAP} state_t;
  state_t state;
  logic [3:0] mode;
  logic [WIDTH_W-1:0] width, gap, wcnt, width_min, gap_min;
  logic [COUNT_W-1:0] count, pulses, count_min, pulses_inc;
  logic [DELAY_W-1:0] delay, dcnt;
  logic done, arm_stb, glitch_en, trig_s0, trig_s1, trig_s2;
  logic req, wr, ctrl_wr, abort, cfg_wr, trig_edge, last_pulse;
  logic [7:0] rdata;
  assign req = bus.stb_i & ~bus.ack_o;
  assign wr = req & bus.we_i;
  assign ctrl_wr = wr & (bus.adr_i == 4'h0);
  assign abort = ctrl_wr & bus.dat_i[1];
  assign cfg_wr = wr & (state == IDLE);
  assign trig_edge = mode[2] ? (trig_s2 & ~trig_s1) : (trig_s1 & ~trig_s2);
  assign width_min = (width == '0) ? WIDTH_W'(1) : width;
  assign gap_min = (gap == '0) ? WIDTH_W'(1) : gap;
  assign count_min = (count == '0) ? COUNT_W'(1) : count;
  assign pulses_inc = (pulses == '1) ? pulses : pulses + COUNT_W'(1);
  assign last_pulse = pulses_inc >= count_min;
  assign clk_out = glitch_en ? ((mode[1:0] == 2'd1) | ((mode[1:0] == 2'd2) & ~clk_in)) : clk_in;
  assign ch_out = {state == DELAY, glitch_en, state == IDLE, arm_stb, clk_in, clk_out};
  always_comb begin
    rdata = '0;
    case (bus.adr_i)
      4'h0: rdata = {5'd0, done, state != IDLE, state == IDLE};
      4'h1: rdata = {4'd0, mode};
      4'h2: rdata = width;
      4'h3: rdata = gap;
      4'h4: rdata = count;
      4'h9: rdata = pulses;
      default: ;
    endcase
    for (int k = 0; k < NB; k++) if (bus.adr_i == 4'(5 + k)) rdata = delay[8*k +: 8];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      mode <= '0;
      width <= '0;
      gap <= '0;
      count <= '0;
      pulses <= '0;
      delay <= '0;
      dcnt <= '0;
      wcnt <= '0;
      done <= 1'b0;
      arm_stb <= 1'b0;
      glitch_en <= 1'b0;
      {trig_s2, trig_s1, trig_s0} <= '0;
      irq_o <= 1'b0;
      bus.ack_o <= 1'b0;
      bus.dat_o <= '0;
    end else begin
      bus.ack_o <= req;
      bus.dat_o <= req ? rdata : 8'd0;
      irq_o <= 1'b0;
      arm_stb <= ctrl_wr & bus.dat_i[0] & ~bus.dat_i[1];
      {trig_s2, trig_s1, trig_s0} <= {trig_s1, trig_s0, trig_in};
      if (ctrl_wr & bus.dat_i[2]) done <= 1'b0;
      if (cfg_wr) begin
        case (bus.adr_i)
          4'h1: mode <= bus.dat_i[3:0];
          4'h2: width <= bus.dat_i;
          4'h3: gap <= bus.dat_i;
          4'h4: count <= bus.dat_i;
          default: ;
        endcase
        for (int k = 0; k < NB; k++) if (bus.adr_i == 4'(5 + k)) delay[8*k +: 8] <= bus.dat_i;
      end
      if (abort) begin
        state <= IDLE;
        glitch_en <= 1'b0;
      end else begin
        case (state)
          IDLE: if (arm_stb) begin
            pulses <= '0;
            if (mode[3]) state <= WAIT_TRIG;
            else if (delay == '0) begin
              state <= PULSE;
              glitch_en <= 1'b1;
              wcnt <= width_min;
            end else begin
              state <= DELAY;
              dcnt <= delay;
            end
          end
          WAIT_TRIG: if (trig_edge) begin
            if (delay == '0) begin
              state <= PULSE;
              glitch_en <= 1'b1;
              wcnt <= width_min;
            end else begin
              state <= DELAY;
              dcnt <= delay;
            end
          end
          DELAY: if (dcnt == DELAY_W'(1)) begin
            state <= PULSE;
            glitch_en <= 1'b1;
            wcnt <= width_min;
          end else dcnt <= dcnt - DELAY_W'(1);
          PULSE: if (wcnt == WIDTH_W'(1)) begin
            glitch_en <= 1'b0;
            pulses <= pulses_inc;
            if (last_pulse) begin
              state <= IDLE;
              done <= 1'b1;
              irq_o <= 1'b1;
            end else begin
              state <= GAP;
              wcnt <= gap_min;
            end
          end else wcnt <= wcnt - WIDTH_W'(1);
          GAP: if (wcnt == WIDTH_W'(1)) begin
            state <= PULSE;
            glitch_en <= 1'b1;
            wcnt <= width_min;
          end else wcnt <= wcnt - WIDTH_W'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_glitch_seq_wb.sv
// tb_glitch_seq_wb: directed register-level bench for the glitch sequencer
module tb_glitch_seq_wb;
  logic clk_i = 1'b0, rst_i = 1'b1, clk_in = 1'b1, trig_in = 1'b0;
  logic clk_out, irq_o;
  logic [5:0] ch_out;
  logic [7:0] rd;
  logic [63:0] pat, exp_pat;
  int checks = 0, failures = 0, glitch_cnt = 0, irq_cnt = 0;
  int first_k, irq_k, gc, ic, dc, g0, i0;
  glitch_seq_wb_if bus();
  glitch_seq_wb #(.DELAY_W(24)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .clk_in(clk_in), .trig_in(trig_in),
    .clk_out(clk_out), .irq_o(irq_o), .ch_out(ch_out)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    glitch_cnt += int'(ch_out[4]);
    irq_cnt += int'(irq_o);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_i);
    bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = a; bus.dat_i = d;
    @(negedge clk_i);
    bus.stb_i = 1'b0; bus.we_i = 1'b0;
  endtask
  task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk_i);
    bus.stb_i = 1'b1; bus.we_i = 1'b0; bus.adr_i = a;
    @(negedge clk_i);
    d = bus.dat_o;
    bus.stb_i = 1'b0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask
  initial begin
    bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;
    cyc(3);
    check("rst_ack", bus.ack_o, 0);
    check("rst_dat", bus.dat_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_clk_out", clk_out, 1);
    rst_i = 1'b0;
    rd_reg(4'h0, rd); check("rst_ctrl", rd, 8'h01);
    rd_reg(4'h2, rd); check("rst_width", rd, 8'h00);
    // single pulse after a 16-cycle delay
    wr(4'h5, 8'h10); wr(4'h2, 8'd3); wr(4'h4, 8'd1); wr(4'h1, 8'h0); wr(4'h0, 8'h01);
    first_k = -1; irq_k = -1; gc = 0; ic = 0; dc = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_i);
      if (ch_out[4]) begin
        if (first_k < 0) first_k = k;
        gc++;
      end
      if (irq_o) begin
        irq_k = k;
        ic++;
      end
      if (ch_out[5]) dc++;
      if (k == 18) check("t2_clk_forced_low", clk_out, 0);
    end
    check("t2_glitch_start", first_k, 17);
    check("t2_glitch_len", gc, 3);
    check("t2_delay_len", dc, 16);
    check("t2_irq_at", irq_k, 20);
    check("t2_irq_count", ic, 1);
    rd_reg(4'h0, rd); check("t2_ctrl", rd, 8'h05);
    rd_reg(4'h9, rd); check("t2_pulses", rd, 8'd1);
    // 4-pulse train, 2 on / 5 off
    wr(4'h0, 8'h04); wr(4'h5, 8'h00); wr(4'h2, 8'd2); wr(4'h3, 8'd5); wr(4'h4, 8'd4); wr(4'h0, 8'h01);
    pat = '0; exp_pat = '0; irq_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      pat[k] = ch_out[4];
      if (irq_o) irq_k = k;
    end
    for (int p = 0; p < 4; p++) begin
      exp_pat[1 + 7*p] = 1'b1;
      exp_pat[2 + 7*p] = 1'b1;
    end
    check("t3_pattern", pat, exp_pat);
    check("t3_irq_at", irq_k, 24);
    rd_reg(4'h9, rd); check("t3_pulses", rd, 8'd4);
    rd_reg(4'h0, rd); check("t3_ctrl", rd, 8'h05);
    // falling-edge external trigger
    wr(4'h0, 8'h04); wr(4'h5, 8'd5); wr(4'h2, 8'd2); wr(4'h4, 8'd1); wr(4'h1, 8'h0C); wr(4'h0, 8'h01);
    cyc(5);
    check("t4_waiting_busy", ch_out[3], 0);
    check("t4_no_delay_yet", ch_out[5], 0);
    @(negedge clk_i); trig_in = 1'b1;
    cyc(10);
    check("t4_rise_ignored", ch_out[5], 0);
    @(negedge clk_i); trig_in = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (ch_out[5] && first_k < 0) first_k = k;
    end
    check("t4_delay_entry", first_k, 3);
    cyc(10);
    rd_reg(4'h0, rd); check("t4_ctrl", rd, 8'h05);
    // abort during a long delay
    wr(4'h0, 8'h04); wr(4'h1, 8'h0); wr(4'h5, 8'hE8); wr(4'h6, 8'h03); wr(4'h2, 8'd3); wr(4'h4, 8'd1);
    g0 = glitch_cnt; i0 = irq_cnt;
    wr(4'h0, 8'h01);
    cyc(100);
    check("t5_in_delay", ch_out[5], 1);
    wr(4'h0, 8'h02);
    check("t5_idle_after_abort", ch_out[3], 1);
    cyc(20);
    check("t5_no_glitch", glitch_cnt - g0, 0);
    check("t5_no_irq", irq_cnt - i0, 0);
    rd_reg(4'h0, rd); check("t5_ctrl", rd, 8'h01);
    rd_reg(4'h9, rd); check("t5_pulses", rd, 8'd0);
    // busy write protection, re-arm, unmapped address
    wr(4'h0, 8'h01);
    cyc(5);
    wr(4'h2, 8'h55);
    rd_reg(4'h2, rd); check("t6_width_locked", rd, 8'd3);
    wr(4'h0, 8'h01);
    cyc(2);
    check("t6_still_delay", ch_out[5], 1);
    rd_reg(4'hF, rd); check("t6_unmapped_rd", rd, 8'h00);
    check("t6_unmapped_ack", bus.ack_o, 1);
    cyc(1);
    check("t6_ack_one_cycle", bus.ack_o, 0);
    wr(4'h0, 8'h02);
    wr(4'h5, 8'h00); wr(4'h6, 8'h00);
    g0 = glitch_cnt;
    wr(4'h0, 8'h03);
    cyc(3);
    check("t6_abort_wins_idle", ch_out[3], 1);
    check("t6_abort_wins_noglitch", glitch_cnt - g0, 0);
    // invert mode
    wr(4'h1, 8'h02); wr(4'h2, 8'd5);
    clk_in = 1'b0;
    wr(4'h0, 8'h01);
    cyc(2);
    check("t7_inv_low", clk_out, 1);
    clk_in = 1'b1;
    #1 check("t7_inv_high", clk_out, 0);
    cyc(8);
    check("t7_done_idle", ch_out[3], 1);
    // async reset in the middle of a pulse
    wr(4'h0, 8'h04); wr(4'h1, 8'h00); wr(4'h2, 8'd200); wr(4'h0, 8'h01);
    cyc(3);
    check("t8_forced", clk_out, 0);
    #2 rst_i = 1'b1;
    #1 check("t8_rst_clk_out", clk_out, 1);
    check("t8_rst_glitch_en", ch_out[4], 0);
    @(negedge clk_i); rst_i = 1'b0;
    rd_reg(4'h1, rd); check("t8_mode", rd, 8'h00);
    rd_reg(4'h2, rd); check("t8_width", rd, 8'h00);
    rd_reg(4'h5, rd); check("t8_delay0", rd, 8'h00);
    rd_reg(4'h0, rd); check("t8_ctrl", rd, 8'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
